fifo_sync_param: RTL and testbench

Parametrised single-clock circular-buffer FIFO, the next-generation replacement for the fixed 8-bit × 16 shift-register FIFO in the synchronous FIFO library. It uses read/write pointers instead of shifting storage, and supports configurable width and depth. It accepts a read and a write in the same cycle, including at full, and adds occupancy count, almost-full/almost-empty thresholds, and a registered read-valid strobe. It sits between a single-clock producer and consumer that need elastic buffering with back-pressure.

---
 rtl/fifo_sync_param_if.sv | 35 +++
 rtl/fifo_sync_param.sv | 107 ++++++++++
 tb/tb_fifo_sync_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: write/read/status bundle for fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, rd_valid, full, empty,
      input  almost_full, almost_empty,
      input  count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, rd_valid, full, empty,
      output almost_full, almost_empty,
      output count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock circular-buffer FIFO, DEPTH x DATA_W.
// Ports: clk, reset (sync, active-high), bus (fifo_sync_param_if.slave):
//   wr_en/din write, rd_en read -> dout/rd_valid (registered),
//   full/empty/almost_full/almost_empty/count status,
//   overflow/underflow sticky error flags.
// Macro FIFO_SYNC_ERR_FLAGS_EN enables the sticky error flags;
// when undefined they are tied to 0.
module fifo_sync_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   fifo_sync_param_if.slave        bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CW     = ADDR_W + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CW-1:0]     count_q;
   logic [DATA_W-1:0] dout_q;
   logic              rd_valid_q;

   logic full;
   logic empty;
   logic wr_acc;
   logic rd_acc;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // A write at full is still accepted when a read frees a slot
   // in the same cycle.
   assign rd_acc = bus.rd_en && !empty;
   assign wr_acc = bus.wr_en && (!full || rd_acc);

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            dout_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.dout         = dout_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);

`ifdef FIFO_SYNC_ERR_FLAGS_EN
   logic ovf_q;
   logic udf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.wr_en && !wr_acc) begin
            ovf_q <= 1'b1;
         end
         if (bus.rd_en && empty) begin
            udf_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: table vectors, directed corner sequences and
// random traffic checked against a queue-based FIFO model.
module tb_fifo_sync_param;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AF_T   = DEPTH - 2;
   localparam int AE_T   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   fifo_sync_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH),
      .AF_THRESH(AF_T), .AE_THRESH(AE_T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model
   logic [DATA_W-1:0] q [$];
   logic [DATA_W-1:0] m_dout;
   logic              m_rv;
   logic              m_ovf;
   logic              m_udf;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic chk_all();
      int sz;
      sz = q.size();
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      chk("count", 32'(bus.count), sz);
      chk("full", 32'(bus.full), 32'(sz == DEPTH));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(sz >= AF_T));
      chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_T));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_udf));
   endtask

   // Drive one cycle, advance model across the edge, compare after it.
   task automatic step(input logic w, input logic r,
                       input logic [DATA_W-1:0] d, input logic rst);
      bit ra;
      bit wa;
      bus.wr_en = w;
      bus.rd_en = r;
      bus.din   = d;
      reset     = rst;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_dout = '0;
         m_rv   = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         ra = r && (q.size() > 0);
         wa = w && ((q.size() < DEPTH) || ra);
         if (ERR_EN && w && !wa) m_ovf = 1'b1;
         if (ERR_EN && r && q.size() == 0) m_udf = 1'b1;
         m_rv = ra;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(d);
      end
      #1;
      chk_all();
   endtask

   typedef struct {
      logic              wr;
      logic              rd;
      logic [DATA_W-1:0] din;
      int                e_count;
      logic [DATA_W-1:0] e_dout;
      logic              e_rv;
   } vec_t;

   vec_t vt [8];

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
      reset     = 1'b1;

      vt[0] = '{1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0};
      vt[1] = '{1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0};
      vt[2] = '{1'b0, 1'b1, 8'h00, 1, 8'h11, 1'b1};
      vt[3] = '{1'b1, 1'b1, 8'h33, 1, 8'h22, 1'b1};
      vt[4] = '{1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b1};
      vt[5] = '{1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0};
      vt[6] = '{1'b1, 1'b1, 8'h44, 1, 8'h33, 1'b0};
      vt[7] = '{1'b0, 1'b1, 8'h00, 0, 8'h44, 1'b1};

      // Reset state
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_dout", 32'(bus.dout), 0);

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         step(vt[i].wr, vt[i].rd, vt[i].din, 1'b0);
         chk($sformatf("vt%0d_count", i), 32'(bus.count), vt[i].e_count);
         chk($sformatf("vt%0d_dout", i), 32'(bus.dout), 32'(vt[i].e_dout));
         chk($sformatf("vt%0d_rv", i), 32'(bus.rd_valid), 32'(vt[i].e_rv));
      end
      chk("vt_underflow", 32'(bus.underflow), 32'(ERR_EN));

      // Fill to full, then one extra write
      step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0);
         chk("af_edge", 32'(bus.almost_full), 32'(i >= AF_T));
      end
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_count", 32'(bus.count), DEPTH);
      step(1'b1, 1'b0, 8'hEE, 1'b0);
      chk("ovf_17th", 32'(bus.overflow), 32'(ERR_EN));
      chk("ovf_count", 32'(bus.count), DEPTH);

      // Drain back-to-back
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, 1'b1, '0, 1'b0);
         chk("drain_dout", 32'(bus.dout), i);
         chk("drain_rv", 32'(bus.rd_valid), 1);
      end
      chk("drain_empty", 32'(bus.empty), 1);

      // Simultaneous read/write at full
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
      step(1'b1, 1'b1, 8'hAA, 1'b0);
      chk("full_rw_dout", 32'(bus.dout), 32'h01);
      chk("full_rw_count", 32'(bus.count), DEPTH);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
      chk("full_rw_last", 32'(bus.dout), 32'hAA);

      // Simultaneous read/write at empty
      step(1'b1, 1'b1, 8'h55, 1'b0);
      chk("empty_rw_rv", 32'(bus.rd_valid), 0);
      chk("empty_rw_count", 32'(bus.count), 1);
      chk("empty_rw_udf", 32'(bus.underflow), 32'(ERR_EN));
      step(1'b0, 1'b1, '0, 1'b0);
      chk("empty_rw_next", 32'(bus.dout), 32'h55);

      // Steady traffic at count=3, pointers wrap
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 8'(i), 1'b0);
         chk("steady_count", 32'(bus.count), 3);
      end

      // Reset mid-operation with pending write
      step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(i + 1), 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0);
      step(1'b1, 1'b0, 8'h99, 1'b1);
      chk("mid_rst_count", 32'(bus.count), 0);
      chk("mid_rst_empty", 32'(bus.empty), 1);
      chk("mid_rst_dout", 32'(bus.dout), 0);
      chk("mid_rst_udf", 32'(bus.underflow), 0);

      // Random traffic with varying write/read bias
      for (int ph = 0; ph < 6; ph++) begin
         int pw;
         int pr;
         pw = (ph % 2 == 0) ? 75 : 30;
         pr = (ph % 2 == 0) ? 30 : 75;
         if (ph >= 4) begin
            pw = 50;
            pr = 50;
         end
         for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                 8'($urandom), 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
